hazard_ctrl: RTL

Pipeline hazard controller for the five-stage predicted RISC core. It drives the stall and flush inputs of the F/D, D/E, E/M and M/W pipeline registers and the PC enable. It resolves load-use hazards, branch mispredictions and multi-cycle data-memory waits with a fixed priority. A memory-wait watchdog is always present; optional performance counters are compiled in by macro.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/hazard_perf_cnt.sv | 30 +++
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg -- definitions shared by the pipeline control blocks.
//   REG_W      : architectural register index width
//   X0         : index of the hard-wired zero register
//   hz_state_t : hazard controller FSM state {RUN, MEM_WAIT}
package pipe_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] X0 = '0;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt -- performance counters for the hazard controller.
// Both counters wrap modulo 2^CNT_W and clear on reset.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   stall_inc     : count one stall cycle this cycle
//   flush_inc     : count one front-end flush this cycle
//   stall_cycles  : cycles with the PC held
//   flush_count   : cycles with the F/D register flushed
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_inc,
    input  logic             flush_inc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_inc) stall_cycles <= stall_cycles + 1'b1;
            if (flush_inc) flush_count  <= flush_count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for the five-stage core.
// Drives PC enable plus stall/flush controls of the F/D, D/E, E/M and M/W
// registers. Fixed priority: memory wait > misprediction > load-use > none.
// All controls are combinational so the pipeline registers act on them at
// the same edge. A watchdog pulses mem_timeout after WAIT_LIMIT consecutive
// wait cycles but never releases the stall.
// Optional feature: define HAZARD_CTRL_PERF_EN to build the performance
// counters; otherwise stall_cycles and flush_count are tied to 0.
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   rs1_d, rs2_d, use_rs*_d  : source registers of D and whether they are read
//   rd_e, memread_e          : destination of E and whether E is a load
//   mispredict_e             : branch in E resolved against the prediction
//   mem_req_m, mem_ready_m   : M accesses memory / access completes this cycle
//   pc_en, stall_*, flush_*  : pipeline controls
//   mem_timeout              : one-cycle watchdog pulse
//   stall_cycles, flush_count: performance counters
//   state_dbg                : current FSM state for observation
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int WAIT_LIMIT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs1_d,
    input  logic [REG_W-1:0] rs2_d,
    input  logic             use_rs1_d,
    input  logic             use_rs2_d,
    input  logic [REG_W-1:0] rd_e,
    input  logic             memread_e,
    input  logic             mispredict_e,
    input  logic             mem_req_m,
    input  logic             mem_ready_m,
    output logic             pc_en,
    output logic             stall_fd,
    output logic             flush_fd,
    output logic             stall_de,
    output logic             flush_de,
    output logic             stall_em,
    output logic             flush_mw,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output hz_state_t        state_dbg
);

    localparam int WC_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [WC_W-1:0] LIMIT_V  = WC_W'(WAIT_LIMIT);
    localparam logic [WC_W-1:0] LIMIT_M1 = WC_W'(WAIT_LIMIT - 1);

    hz_state_t       state, state_nxt;
    logic [WC_W-1:0] wait_cnt;
    logic            mem_wait;
    logic            load_use;

    assign mem_wait = mem_req_m & ~mem_ready_m;
    assign load_use = memread_e & (rd_e != X0) &
                      ((use_rs1_d & (rs1_d == rd_e)) | (use_rs2_d & (rs2_d == rd_e)));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    // Next state: a ready cycle or a dropped request ends the wait
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      if (mem_wait) state_nxt = MEM_WAIT;
            MEM_WAIT: if (mem_ready_m || !mem_req_m) state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
    end

    // Outputs. The wait condition is evaluated from the live inputs so the
    // first wait cycle (still in RUN) stalls as well, and the ready cycle
    // (still in MEM_WAIT) already follows normal priority.
    always_comb begin
        pc_en    = 1'b1;
        stall_fd = 1'b0;
        flush_fd = 1'b0;
        stall_de = 1'b0;
        flush_de = 1'b0;
        stall_em = 1'b0;
        flush_mw = 1'b0;
        if (reset) begin
            pc_en    = 1'b0;
            flush_fd = 1'b1;
            flush_de = 1'b1;
            flush_mw = 1'b1;
        end else if (mem_wait) begin
            pc_en    = 1'b0;
            stall_fd = 1'b1;
            stall_de = 1'b1;
            stall_em = 1'b1;
            flush_mw = 1'b1;
        end else if (mispredict_e) begin
            flush_fd = 1'b1;
            flush_de = 1'b1;
        end else if (load_use) begin
            pc_en    = 1'b0;
            stall_fd = 1'b1;
            flush_de = 1'b1;
        end
    end

    // Watchdog: counts consecutive wait cycles, saturating at WAIT_LIMIT
    always_ff @(posedge clk) begin
        if (reset || !mem_wait)     wait_cnt <= '0;
        else if (wait_cnt != LIMIT_V) wait_cnt <= wait_cnt + 1'b1;
    end

    // Pulse on the cycle the count steps onto the limit
    assign mem_timeout = ~reset & mem_wait & (wait_cnt == LIMIT_M1);

    assign state_dbg = state;

`ifdef HAZARD_CTRL_PERF_EN
    hazard_perf_cnt #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk         (clk),
        .reset       (reset),
        .stall_inc   (~pc_en & ~reset),
        .flush_inc   (flush_fd & ~reset),
        .stall_cycles(stall_cycles),
        .flush_count (flush_count)
    );
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
